// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA-style timing generator.
//
// Produces the pixel column (hc) and line (vc) counters plus hsync, vsync,
// display enable, a start-of-frame pulse and an 8-bit frame counter.
// Each axis is laid out as: active, front porch, sync, back porch. The
// active region starts at count 0.
//
// The sync/enable outputs are registered. They are decoded from the
// *next* counter values, so they line up with the hc/vc visible in the
// same cycle. No input reaches any output through combinational logic.
//
// Optional feature: define SYNC_PIPE_EN to delay hsync, vsync, de and
// frame_start by one extra register stage. This lines them up with a
// downstream colour lookup that has one cycle of latency. hc, vc and
// frame_cnt keep their timing.
//
// HTOTAL and VTOTAL must each be at most 2048, so the last count fits in
// the 11-bit counters.
module vga_sync_gen #(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSW     = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSW     = 2,
  parameter int VBP     = 33,
  parameter int HPOL    = 0,
  parameter int VPOL    = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;

  // Region boundaries are held one bit wider than the counters. A boundary
  // can then equal 2048 without wrapping to zero.
  localparam logic [11:0] H_ACT_END  = 12'(HACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(HACTIVE + HFP);
  localparam logic [11:0] H_SYNC_END = 12'(HACTIVE + HFP + HSW);
  localparam logic [10:0] H_LAST     = 11'(HTOTAL - 1);

  localparam logic [11:0] V_ACT_END  = 12'(VACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(VACTIVE + VFP);
  localparam logic [11:0] V_SYNC_END = 12'(VACTIVE + VFP + VSW);
  localparam logic [10:0] V_LAST     = 11'(VTOTAL - 1);

  // Asserted sync levels. The idle level is the complement.
  localparam logic H_ON = (HPOL != 0);
  localparam logic V_ON = (VPOL != 0);

  logic [10:0] r_hc;
  logic [10:0] r_vc;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic        r_frameStart;
  logic [7:0]  r_frameCnt;

  logic        w_hWrap;
  logic        w_vWrap;
  logic [10:0] w_hcNext;
  logic [10:0] w_vcNext;
  logic [11:0] w_hcNextExt;
  logic [11:0] w_vcNextExt;
  logic        w_hsyncNext;
  logic        w_vsyncNext;
  logic        w_deNext;
  logic        w_frameStartNext;

  // Next counter values. The line counter advances only when the column wraps.
  always_comb begin
    w_hWrap  = (r_hc == H_LAST);
    w_vWrap  = w_hWrap && (r_vc == V_LAST);
    w_hcNext = w_hWrap ? 11'd0 : r_hc + 11'd1;
    w_vcNext = r_vc;
    if (w_hWrap) begin
      w_vcNext = (r_vc == V_LAST) ? 11'd0 : r_vc + 11'd1;
    end
  end

  // Decode the sync/enable levels belonging to the next (hc, vc) position.
  // A new frame begins only when both counters wrap on the same edge.
  always_comb begin
    w_hcNextExt      = {1'b0, w_hcNext};
    w_vcNextExt      = {1'b0, w_vcNext};
    w_hsyncNext      = ((w_hcNextExt >= H_SYNC_BEG) && (w_hcNextExt < H_SYNC_END)) ? H_ON : ~H_ON;
    w_vsyncNext      = ((w_vcNextExt >= V_SYNC_BEG) && (w_vcNextExt < V_SYNC_END)) ? V_ON : ~V_ON;
    w_deNext         = (w_hcNextExt < H_ACT_END) && (w_vcNextExt < V_ACT_END);
    w_frameStartNext = w_vWrap;
  end

  // Column and line counters. Reset aborts the current frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hc <= 11'd0;
      r_vc <= 11'd0;
    end else begin
      r_hc <= w_hcNext;
      r_vc <= w_vcNext;
    end
  end

  // Register the decoded levels, so they match the counters updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync      <= ~H_ON;
      r_vsync      <= ~V_ON;
      r_de         <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_hsync      <= w_hsyncNext;
      r_vsync      <= w_vsyncNext;
      r_de         <= w_deNext;
      r_frameStart <= w_frameStartNext;
    end
  end

  // Frame counter. It steps on the edge that raises the start-of-frame pulse and wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameCnt <= 8'd0;
    end else if (w_frameStartNext) begin
      r_frameCnt <= r_frameCnt + 8'd1;
    end
  end

`ifdef SYNC_PIPE_EN
  logic r_hsyncPipe;
  logic r_vsyncPipe;
  logic r_dePipe;
  logic r_frameStartPipe;

  // Extra stage. It delays the sync/enable outputs by one cycle relative to hc/vc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsyncPipe      <= ~H_ON;
      r_vsyncPipe      <= ~V_ON;
      r_dePipe         <= 1'b0;
      r_frameStartPipe <= 1'b0;
    end else begin
      r_hsyncPipe      <= r_hsync;
      r_vsyncPipe      <= r_vsync;
      r_dePipe         <= r_de;
      r_frameStartPipe <= r_frameStart;
    end
  end

  assign hsync       = r_hsyncPipe;
  assign vsync       = r_vsyncPipe;
  assign de          = r_dePipe;
  assign frame_start = r_frameStartPipe;
`else
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frameStart;
`endif

  assign hc        = r_hc;
  assign vc        = r_vc;
  assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen -- bench for vga_sync_gen.
// Two small-geometry instances with opposite sync polarities share one
// clock and one reset. Expected outputs come from the elapsed cycle count
// since reset release. They use plain modulo/divide arithmetic.
module tb_vga_sync_gen;

  // Geometry A: 12 x 9 positions, hsync active low, vsync active high.
  localparam int A_HA = 6, A_HFP = 2, A_HSW = 3, A_HBP = 1;
  localparam int A_VA = 4, A_VFP = 1, A_VSW = 2, A_VBP = 2;
  localparam int A_HPOL = 0, A_VPOL = 1;
  // Geometry B: 16 x 6 positions, no vertical back porch, hsync active high.
  localparam int B_HA = 10, B_HFP = 1, B_HSW = 2, B_HBP = 3;
  localparam int B_VA = 3, B_VFP = 2, B_VSW = 1, B_VBP = 0;
  localparam int B_HPOL = 1, B_VPOL = 0;

`ifdef SYNC_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol;
  } geom_t;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        fs;
    logic [7:0]  fcnt;
  } outs_t;

  typedef struct packed {
    outs_t a;
    outs_t b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [10:0] hcA, vcA, hcB, vcB;
  logic        hsyncA, vsyncA, deA, fsA, hsyncB, vsyncB, deB, fsB;
  logic [7:0]  fcntA, fcntB;

  geom_t gA, gB;
  exp_t  expQ[$];
  int    t;
  int    checks;
  int    errors;
  bit    running;

  vga_sync_gen #(
    .HACTIVE(A_HA), .HFP(A_HFP), .HSW(A_HSW), .HBP(A_HBP),
    .VACTIVE(A_VA), .VFP(A_VFP), .VSW(A_VSW), .VBP(A_VBP),
    .HPOL(A_HPOL), .VPOL(A_VPOL)
  ) dutA (
    .clk(clk), .rst(rst), .hc(hcA), .vc(vcA), .hsync(hsyncA), .vsync(vsyncA),
    .de(deA), .frame_start(fsA), .frame_cnt(fcntA)
  );

  vga_sync_gen #(
    .HACTIVE(B_HA), .HFP(B_HFP), .HSW(B_HSW), .HBP(B_HBP),
    .VACTIVE(B_VA), .VFP(B_VFP), .VSW(B_VSW), .VBP(B_VBP),
    .HPOL(B_HPOL), .VPOL(B_VPOL)
  ) dutB (
    .clk(clk), .rst(rst), .hc(hcB), .vc(vcB), .hsync(hsyncB), .vsync(vsyncB),
    .de(deB), .frame_start(fsB), .frame_cnt(fcntB)
  );

  // Free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output values while reset is held
  function automatic outs_t resetOuts(input geom_t g);
    outs_t o;
    o.hc    = 11'd0;
    o.vc    = 11'd0;
    o.hsync = (g.hpol == 0);
    o.vsync = (g.vpol == 0);
    o.de    = 1'b0;
    o.fs    = 1'b0;
    o.fcnt  = 8'd0;
    return o;
  endfunction

  // Outputs t clocks after reset release, without any extra pipeline delay
  function automatic outs_t nominal(input int tc, input geom_t g);
    outs_t o;
    int htot, vtot, frame, h, v;
    htot    = g.ha + g.hfp + g.hsw + g.hbp;
    vtot    = g.va + g.vfp + g.vsw + g.vbp;
    frame   = htot * vtot;
    h       = tc % htot;
    v       = (tc / htot) % vtot;
    o.hc    = 11'(h);
    o.vc    = 11'(v);
    o.hsync = (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hsw) ? (g.hpol != 0) : (g.hpol == 0);
    o.vsync = (v >= g.va + g.vfp && v < g.va + g.vfp + g.vsw) ? (g.vpol != 0) : (g.vpol == 0);
    o.de    = (tc != 0) && (h < g.ha) && (v < g.va);
    o.fs    = (tc != 0) && (tc % frame == 0);
    o.fcnt  = 8'((tc / frame) % 256);
    return o;
  endfunction

  // Expected outputs. With the pipe build, sync/enable lag hc/vc by one clock.
  function automatic outs_t expected(input int tc, input geom_t g);
    outs_t n, p;
    n = nominal(tc, g);
    if (PIPE) begin
      p = (tc == 0) ? resetOuts(g) : nominal(tc - 1, g);
      n.hsync = p.hsync;
      n.vsync = p.vsync;
      n.de    = p.de;
      n.fs    = p.fs;
    end
    return n;
  endfunction

  // One clock of stimulus. Reset changes 3 time units after the edge, so assertion lands mid-cycle.
  task automatic applyStimulus(input logic rstVal);
    exp_t e;
    @(posedge clk);
    if (!rst) t++;
    #3;
    rst = rstVal;
    if (rst) t = 0;
    e.a = rst ? resetOuts(gA) : expected(t, gA);
    e.b = rst ? resetOuts(gB) : expected(t, gB);
    expQ.push_back(e);
  endtask

  task automatic cmpField(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input outs_t act, input outs_t req);
    cmpField({tag, ".hc"},          act.hc,           req.hc);
    cmpField({tag, ".vc"},          act.vc,           req.vc);
    cmpField({tag, ".hsync"},       11'(act.hsync),   11'(req.hsync));
    cmpField({tag, ".vsync"},       11'(act.vsync),   11'(req.vsync));
    cmpField({tag, ".de"},          11'(act.de),      11'(req.de));
    cmpField({tag, ".frame_start"}, 11'(act.fs),      11'(req.fs));
    cmpField({tag, ".frame_cnt"},   11'(act.fcnt),    11'(req.fcnt));
  endtask

  // Monitor. On each falling edge it takes the oldest expectation and compares it with both instances.
  initial begin
    outs_t actA, actB;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (running) begin
        actA = {hcA, vcA, hsyncA, vsyncA, deA, fsA, fcntA};
        actB = {hcB, vcB, hsyncB, vsyncB, deB, fsB, fcntB};
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL queue_empty actual=0 required=1 at %0t", $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("A", actA, e.a);
          checkOutput("B", actB, e.b);
        end
      end
    end
  end

  // Main sequence. A long run wraps frame_cnt on both instances, then random mid-frame resets follow.
  initial begin
    int runLen, rstLen;
    gA = '{A_HA, A_HFP, A_HSW, A_HBP, A_VA, A_VFP, A_VSW, A_VBP, A_HPOL, A_VPOL};
    gB = '{B_HA, B_HFP, B_HSW, B_HBP, B_VA, B_VFP, B_VSW, B_VBP, B_HPOL, B_VPOL};
    checks  = 0;
    errors  = 0;
    t       = 0;
    rst     = 1'b1;
    running = 1'b1;
    $display("[TB] start, pipe=%0d", PIPE);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    for (int i = 0; i < 28000; i++) applyStimulus(1'b0);
    for (int s = 0; s < 25; s++) begin
      rstLen = $urandom_range(1, 3);
      runLen = $urandom_range(1, 600);
      for (int i = 0; i < rstLen; i++) applyStimulus(1'b1);
      for (int i = 0; i < runLen; i++) applyStimulus(1'b0);
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch
- HSW, 96, hsync width
- HBP, 48, horizontal back porch
- VACTIVE, 480, visible lines
- VFP, 10, vertical front porch
- VSW, 2, vsync width
- VBP, 33, vertical back porch
- HPOL, 0, hsync active level
- VPOL, 0, vsync active level
REQ-002 Derived constants SHALL be HTOTAL = HACTIVE+HFP+HSW+HBP and VTOTAL = VACTIVE+VFP+VSW+VBP; both SHALL be at most 2048.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- hc, out, 11, current pixel column (feeds the sprite stage hc)
- vc, out, 11, current line (feeds the sprite stage vc)
- hsync, out, 1, horizontal sync at HPOL level when active
- vsync, out, 1, vertical sync at VPOL level when active
- de, out, 1, display enable (visible region)
- frame_start, out, 1, single-cycle pulse at start of frame
- frame_cnt, out, 8, frame counter

Function
REQ-004 hc SHALL increment by 1 each clk and wrap from HTOTAL-1 to 0.
REQ-005 vc SHALL increment by 1 on each hc wrap and wrap from VTOTAL-1 to 0 when hc wraps on line VTOTAL-1.
REQ-006 Region order SHALL be active, front porch, sync, back porch, in both axes, with the active region starting at count 0.
REQ-007 hsync SHALL be at HPOL when HACTIVE+HFP <= hc < HACTIVE+HFP+HSW, and at ~HPOL otherwise.
REQ-008 vsync SHALL be at VPOL when VACTIVE+VFP <= vc < VACTIVE+VFP+VSW, and at ~VPOL otherwise; vsync SHALL change only on hc wrap.
REQ-009 de SHALL be 1 iff hc < HACTIVE and vc < VACTIVE.
REQ-010 hsync, vsync, de and frame_start SHALL be registered outputs, each decoded from the next-state counter values so that, by default, they align with the hc/vc present in the same cycle (zero relative latency).
REQ-011 frame_start SHALL be 1 for exactly the one cycle in which hc=0 and vc=0 is reached by counter wrap.
REQ-012 frame_start SHALL NOT pulse on reset release.
REQ-013 frame_cnt SHALL increment on the same clock edge that raises frame_start, and SHALL wrap from 255 to 0.
REQ-014 The hc wrap and the vc wrap occurring on the same edge SHALL produce exactly one frame_start and exactly one frame_cnt increment.
REQ-015 All outputs SHALL be glitch-free register outputs; no combinational path SHALL exist from any input to any output.

Reset
REQ-016 While rst=1, the outputs SHALL hold: hc=0, vc=0, de=0, hsync=~HPOL, vsync=~VPOL, frame_start=0, frame_cnt=0.
REQ-017 Reset SHALL take effect asynchronously; assertion mid-line or mid-frame SHALL abort the current frame immediately.
REQ-018 On the first clk edge after rst deasserts, hc SHALL become 1 and vc SHALL remain 0.
REQ-019 The reset-time de=0 at (0,0) SHALL be the only de deviation; the first frame SHALL otherwise be complete.

Configuration
REQ-020 When macro SYNC_PIPE_EN is defined, hsync, vsync, de and frame_start SHALL each be delayed by one extra register stage relative to hc/vc, matching the one-cycle colour-lookup latency of the downstream sprite stage; hc, vc and frame_cnt SHALL be unaffected.
REQ-021 Under SYNC_PIPE_EN, the extra pipeline registers SHALL reset to the values given in REQ-016.
REQ-022 When SYNC_PIPE_EN is undefined, the timing of REQ-010 SHALL apply and no extra registers SHALL be present.

Verification
REQ-023 Default parameters, release reset, run 2 frames -> hc period 800 clocks, vc period 525 lines, 420000 clocks between frame_start pulses, frame_cnt 0->1->2.
REQ-024 Default parameters, first line after reset -> hsync low exactly for hc 656..751 (96 clocks); de high for hc 1..639 on the first line and for hc 0..639 on every other visible line.
REQ-025 Default parameters -> vsync low exactly for lines 490..491; vsync toggles only on the edge where hc goes 799->0.
REQ-026 HPOL=1, VPOL=1 -> hsync and vsync inverted relative to REQ-024/REQ-025; reset value hsync=0, vsync=0.
REQ-027 Assert rst at hc=300, vc=200 for 3 clocks -> all outputs immediately take their REQ-016 values; after release, frame_cnt=0 and the next frame_start occurs 420000 clocks after the release edge.
REQ-028 SYNC_PIPE_EN defined -> de rises one clock after hc=0 on line 1 and falls one clock after hc=640; frame_start is high in the cycle where hc=1 and vc=0; frame_cnt wraps 255->0 after 256 frames.
